// File: rtl/bcd_down_timer_pkg.sv
// Shared constants for the BCD down-timer: FSM state encoding, digit width, and the clamp applied to loaded digits.
package bcd_down_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_timer_if.sv
// Control and status bundle for the BCD down-timer: load/enable in, count/flags out.
interface bcd_down_timer_if #(parameter int DIGITS = 2);

    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  en;
    logic [4*DIGITS-1:0]   count;
    logic                  zero;
    logic                  done;
    logic                  busy;

    modport master (output load, load_val, en, input count, zero, done, busy);
    modport slave  (input load, load_val, en, output count, zero, done, busy);

endinterface

// File: rtl/bcd_down_timer_digit.sv
// A single BCD decade that counts down. It wraps 0 -> 9 and signals a borrow to the next decade when it does.
module bcd_digit_down
    import bcd_down_timer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_load_digit,
    input  logic             i_dec,
    output logic [BCD_W-1:0] o_digit,
    output logic             o_borrow,
    output logic             o_zero
);

    logic [BCD_W-1:0] r_digit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_digit <= '0;
        else if (i_load)
            r_digit <= i_load_digit;
        else if (i_dec)
            r_digit <= (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
    end

    assign o_digit  = r_digit;
    assign o_zero   = (r_digit == 4'd0);
    assign o_borrow = i_dec && o_zero;

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer: load, enable, terminal detect, one-cycle done pulse, and optional auto-reload.
// States: IDLE = holding, en ignored | RUN = decrementing on en | DONE = one-cycle terminal pulse.
module bcd_down_timer
    import bcd_down_timer_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter bit AUTO_RELOAD = 1'b0
)(
    input  logic              clk,
    input  logic              reset,
    bcd_down_timer_if.slave   bus
);

    localparam int W = BCD_W * DIGITS;

    state_t          r_state, w_state_nxt;
    logic [W-1:0]    r_reload;
    logic [W-1:0]    w_load_san;
    logic [W-1:0]    w_load_mux;
    logic [W-1:0]    w_count;
    logic [DIGITS:0] w_dec;
    logic [DIGITS-1:0] w_dig_zero;
    logic            w_dig_load;
    logic            w_last_step;

    always_comb begin
        w_load_san = '0;
        for (int i = 0; i < DIGITS; i++)
            w_load_san[i*BCD_W +: BCD_W] = bcd_clamp(bus.load_val[i*BCD_W +: BCD_W]);
    end

    assign w_dig_load = bus.load || (AUTO_RELOAD && (r_state == ST_DONE));
    assign w_load_mux = bus.load ? w_load_san : r_reload;
    assign w_dec[0]   = (r_state == ST_RUN) && bus.en && !bus.load;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_down u_digit (
            .clk          (clk),
            .rst_n        (reset),
            .i_load       (w_dig_load),
            .i_load_digit (w_load_mux[g*BCD_W +: BCD_W]),
            .i_dec        (w_dec[g]),
            .o_digit      (w_count[g*BCD_W +: BCD_W]),
            .o_borrow     (w_dec[g+1]),
            .o_zero       (w_dig_zero[g])
        );
    end

    // A borrow out of the top decade would mean RUN held 0; treat it as terminal so the count can never wrap.
    assign w_last_step = w_dec[0] && ((w_count == W'(1)) || w_dec[DIGITS]);

    always_comb begin
        w_state_nxt = r_state;
        if (bus.load) begin
            w_state_nxt = (w_load_san != '0) ? ST_RUN : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_IDLE;
                ST_RUN:  if (w_last_step) w_state_nxt = ST_DONE;
                ST_DONE: w_state_nxt = (AUTO_RELOAD && (r_reload != '0)) ? ST_RUN : ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_reload <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.load)
                r_reload <= w_load_san;
        end
    end

    assign bus.count = w_count;
    assign bus.zero  = &w_dig_zero;
    assign bus.done  = (r_state == ST_DONE);
    assign bus.busy  = (r_state == ST_RUN);

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench: vector tables for a one-shot and an auto-reload instance, plus an asynchronous reset sequence.
module tb_bcd_down_timer;

    typedef struct {
        logic       load;
        logic [7:0] val;
        logic       en;
        logic [7:0] c;
        logic       z;
        logic       d;
        logic       b;
    } vec_t;

    typedef struct {
        logic [7:0] c;
        logic       z;
        logic       d;
        logic       b;
        int         idx;
        bit         sel;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    vec_t va[$];
    vec_t va2[$];
    vec_t vb[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_down_timer_if #(.DIGITS(2)) if_a ();
    bcd_down_timer_if #(.DIGITS(2)) if_b ();

    bcd_down_timer #(.DIGITS(2), .AUTO_RELOAD(1'b0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a.slave)
    );

    bcd_down_timer #(.DIGITS(2), .AUTO_RELOAD(1'b1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.slave)
    );

    function automatic vec_t mk(logic l, logic [7:0] v, logic e,
                                logic [7:0] c, logic z, logic d, logic b);
        vec_t r;
        r.load = l; r.val = v; r.en = e; r.c = c; r.z = z; r.d = d; r.b = b;
        return r;
    endfunction

    task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(bit sel, int idx, vec_t v);
        exp_t e;
        @(negedge clk);
        if (sel) begin
            if_b.load = v.load; if_b.load_val = v.val; if_b.en = v.en;
            if_a.load = 1'b0;   if_a.load_val = 8'h00; if_a.en = 1'b0;
        end else begin
            if_a.load = v.load; if_a.load_val = v.val; if_a.en = v.en;
            if_b.load = 1'b0;   if_b.load_val = 8'h00; if_b.en = 1'b0;
        end
        e.c = v.c; e.z = v.z; e.d = v.d; e.b = v.b; e.idx = idx; e.sel = sel;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.sel) begin
            chk("b_count", e.idx, if_b.count, e.c);
            chk("b_zero",  e.idx, {7'd0, if_b.zero}, {7'd0, e.z});
            chk("b_done",  e.idx, {7'd0, if_b.done}, {7'd0, e.d});
            chk("b_busy",  e.idx, {7'd0, if_b.busy}, {7'd0, e.b});
        end else begin
            chk("a_count", e.idx, if_a.count, e.c);
            chk("a_zero",  e.idx, {7'd0, if_a.zero}, {7'd0, e.z});
            chk("a_done",  e.idx, {7'd0, if_a.done}, {7'd0, e.d});
            chk("a_busy",  e.idx, {7'd0, if_a.busy}, {7'd0, e.b});
        end
    endtask

    initial begin
        // Idle after reset: en toggles must not move the count.
        for (int i = 0; i < 5; i++) va.push_back(mk(1'b0, 8'h00, i[0] ? 1'b0 : 1'b1, 8'h00, 1, 0, 0));
        // Borrow across decades.
        va.push_back(mk(1, 8'h10, 0, 8'h10, 0, 0, 1));
        va.push_back(mk(0, 8'h00, 1, 8'h09, 0, 0, 1));
        va.push_back(mk(0, 8'h00, 1, 8'h08, 0, 0, 1));
        // Terminal count, done pulse, then idle with en held.
        va.push_back(mk(1, 8'h03, 1, 8'h03, 0, 0, 1));
        va.push_back(mk(0, 8'h00, 1, 8'h02, 0, 0, 1));
        va.push_back(mk(0, 8'h00, 1, 8'h01, 0, 0, 1));
        va.push_back(mk(0, 8'h00, 1, 8'h00, 1, 1, 0));
        for (int i = 0; i < 5; i++) va.push_back(mk(0, 8'h00, 1, 8'h00, 1, 0, 0));
        // Enable gating and load beating en.
        va.push_back(mk(1, 8'h05, 0, 8'h05, 0, 0, 1));
        va.push_back(mk(0, 8'h00, 1, 8'h04, 0, 0, 1));
        va.push_back(mk(0, 8'h00, 0, 8'h04, 0, 0, 1));
        va.push_back(mk(0, 8'h00, 1, 8'h03, 0, 0, 1));
        va.push_back(mk(1, 8'h42, 1, 8'h42, 0, 0, 1));
        // Loading zero goes idle without a done pulse.
        va.push_back(mk(1, 8'h00, 1, 8'h00, 1, 0, 0));
        // Load during the DONE cycle wins.
        va.push_back(mk(1, 8'h01, 0, 8'h01, 0, 0, 1));
        va.push_back(mk(0, 8'h00, 1, 8'h00, 1, 1, 0));
        va.push_back(mk(1, 8'h42, 1, 8'h42, 0, 0, 1));
        // Digit clamp, both decades.
        va.push_back(mk(1, 8'h3C, 0, 8'h39, 0, 0, 1));
        va.push_back(mk(1, 8'hFA, 0, 8'h99, 0, 0, 1));
        va.push_back(mk(0, 8'h00, 1, 8'h98, 0, 0, 1));
        va.push_back(mk(1, 8'h25, 0, 8'h25, 0, 0, 1));
        va.push_back(mk(0, 8'h00, 1, 8'h24, 0, 0, 1));
        va.push_back(mk(0, 8'h00, 1, 8'h23, 0, 0, 1));
        va.push_back(mk(0, 8'h00, 1, 8'h22, 0, 0, 1));
        va.push_back(mk(0, 8'h00, 1, 8'h21, 0, 0, 1));
        va.push_back(mk(0, 8'h00, 1, 8'h20, 0, 0, 1));

        // After the mid-count reset: stays idle until a new load.
        va2.push_back(mk(0, 8'h00, 1, 8'h00, 1, 0, 0));
        va2.push_back(mk(0, 8'h00, 1, 8'h00, 1, 0, 0));
        va2.push_back(mk(1, 8'h02, 0, 8'h02, 0, 0, 1));
        va2.push_back(mk(0, 8'h00, 1, 8'h01, 0, 0, 1));

        // Auto-reload: 3-cycle period, then load zero stops it.
        vb.push_back(mk(1, 8'h02, 1, 8'h02, 0, 0, 1));
        vb.push_back(mk(0, 8'h00, 1, 8'h01, 0, 0, 1));
        vb.push_back(mk(0, 8'h00, 1, 8'h00, 1, 1, 0));
        vb.push_back(mk(0, 8'h00, 1, 8'h02, 0, 0, 1));
        vb.push_back(mk(0, 8'h00, 1, 8'h01, 0, 0, 1));
        vb.push_back(mk(0, 8'h00, 1, 8'h00, 1, 1, 0));
        vb.push_back(mk(0, 8'h00, 0, 8'h02, 0, 0, 1));
        vb.push_back(mk(0, 8'h00, 1, 8'h01, 0, 0, 1));
        vb.push_back(mk(1, 8'h00, 1, 8'h00, 1, 0, 0));
        vb.push_back(mk(0, 8'h00, 1, 8'h00, 1, 0, 0));
        vb.push_back(mk(0, 8'h00, 1, 8'h00, 1, 0, 0));

        reset = 1'b0;
        if_a.load = 1'b0; if_a.load_val = 8'h00; if_a.en = 1'b0;
        if_b.load = 1'b0; if_b.load_val = 8'h00; if_b.en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_count", 0, if_a.count, 8'h00);
        chk("rst_zero",  0, {7'd0, if_a.zero}, 8'h01);
        chk("rst_busy",  0, {7'd0, if_a.busy}, 8'h00);
        chk("rst_done",  0, {7'd0, if_a.done}, 8'h00);
        chk("rst_b_cnt", 0, if_b.count, 8'h00);

        foreach (va[i]) apply(1'b0, i, va[i]);

        // Asynchronous reset while RUN holds 20: must clear before any clock edge.
        @(negedge clk);
        if_a.en = 1'b1;
        reset = 1'b0;
        #1;
        chk("async_count", 0, if_a.count, 8'h00);
        chk("async_zero",  0, {7'd0, if_a.zero}, 8'h01);
        chk("async_busy",  0, {7'd0, if_a.busy}, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        foreach (va2[i]) apply(1'b0, 100 + i, va2[i]);
        foreach (vb[i])  apply(1'b1, 200 + i, vb[i]);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Multi-digit BCD (decade) down-counter with load, count enable, terminal detection and a one-cycle done pulse.
- It is the counting-down counterpart of the team's decade up-counter and uses the same clk/reset port naming.
- It serves as a countdown/interval timer for display and sequencing blocks that consume BCD values.
- Optional auto-reload turns it into a periodic tick generator.

Parameters:
- DIGITS, 2, number of cascaded BCD digits; count width is 4*DIGITS.
- AUTO_RELOAD, 0, when 1 the counter reloads the last loaded value after reaching zero and keeps running.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load  input  1  synchronous load strobe.
- load_val  input  4*DIGITS  BCD value to load; digit i occupies bits [4i+3:4i].
- en  input  1  count enable; one decrement per enabled cycle while running.
- count  output  4*DIGITS  current BCD count, registered.
- zero  output  1  high whenever count equals 0; combinational from count.
- done  output  1  registered one-cycle pulse marking the cycle in which the count first reaches 0.
- busy  output  1  high while in state RUN.

Behaviour:
- Reset: while reset=0, asynchronously force count=0, state=IDLE, reload register=0, done=0, busy=0, zero=1.
- States are IDLE, RUN and DONE.
- Load sanitising: any load_val digit >9 is clamped to 9 when captured, both into count and into the reload register.
- Load priority: load=1 beats en and every state, and has no effect when count is unchanged except as below.
  - On the next edge, count takes the sanitised load_val and the reload register takes the same value.
  - If the loaded value is nonzero, next state is RUN; if zero, next state is IDLE and no done pulse is generated.
- RUN with en=1 and load=0: count decrements by 1 in BCD.
  - Digit 0 wraps to 9 and borrows into the next digit.
  - The borrow ripples through all digits within the same cycle.
  - If the post-decrement value is 0, next state is DONE.
- RUN with en=0: hold count and state.
- DONE lasts exactly one cycle; done=1 only in this state and count reads 0 during it.
  - AUTO_RELOAD=0: next state IDLE, count stays 0.
  - AUTO_RELOAD=1: next edge loads count from the reload register and enters RUN. If the reload register is 0, enter IDLE instead.
  - en is ignored in DONE; load still wins, and done remains 1 for that cycle.
- IDLE: count holds; en is ignored, so there is no underflow or wrap below 0.
- Latency: count reflects load or en one clock edge after they are sampled.
- busy is 1 in RUN only.
- Reset mid-count: count clears immediately, without waiting for a clock edge; counting resumes only after reset deasserts and a new load arrives.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE, RUN, DONE);
  - the BCD digit width constant (4);
  - the maximum digit value constant (9).
- One natural sub-module, bcd_digit_down: a single 4-bit BCD digit.
  - Inputs: load, load digit, decrement-in (borrow in).
  - Outputs: digit value, borrow-out (asserted when the digit is 0 and decrement-in is asserted), and digit-is-zero.
  - Instantiate it DIGITS times in a generate chain.
- Top level holds the FSM, the reload register and the zero/done logic.

Test Plan:
1. DIGITS=2: reset low for 3 cycles, then release -> count=8'h00, zero=1, busy=0, done=0. Toggle en for 5 cycles -> count stays 8'h00, done never asserted.
2. Load 8'h10, then en=1 for 2 cycles -> count 8'h09 then 8'h08. The units digit wraps 0 to 9 with a borrow from the tens digit.
3. Load 8'h03 with en held high -> count 02, 01, 00. done=1 only in the first cycle count=00, busy falls the same cycle, then state is IDLE and count stays 00 for 5 more enabled cycles.
4. Load 8'h05 with en pattern 1,0,1 -> count 04, 04, 03. Assert load=1 (8'h42) together with en=1 -> next count 8'h42, no decrement that cycle.
5. Load 8'h3C -> count 8'h39 (digit clamped). Load 8'h25, en for 5 cycles -> 8'h20; pull reset low between edges -> count 8'h00 immediately, before the next clk edge.
6. AUTO_RELOAD=1: load 8'h02 with en held -> 01, 00 (done=1), 02, 01, 00 (done=1), repeating with a 3-cycle period. Load 8'h00 -> IDLE, done stays 0.
